bram_mask_ctrl: RTL

BRAM_MASK_CTRL -- requirements
Module: bram_mask_ctrl

---
 rtl/bram_mask_ctrl_if.sv | 42 ++++
 rtl/bram_mask_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bram_mask_ctrl_if.sv
// ---------------------------------------------------------------------------
// bram_mask_ctrl_if
// Request / read-response handshake bundle for bram_mask_ctrl.
//
//   req_valid / req_ready : request handshake (master -> slave)
//   req_we                : 1 = masked write, 0 = read
//   req_addr              : word address
//   req_wmask             : per-lane write enable, bit i enables lane i
//   req_wdata             : write data
//   rsp_valid / rsp_ready : read response handshake (slave -> master)
//   rsp_data              : read data
//
// master : the requester (drives requests, accepts responses)
// slave  : the controller (accepts requests, drives responses)
// ---------------------------------------------------------------------------
interface bram_mask_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int MASK_WIDTH = 8
);
  localparam int NLANE = DATA_WIDTH / MASK_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NLANE-1:0]      req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_mask_ctrl.sv
// ---------------------------------------------------------------------------
// bram_mask_ctrl
// Controller in front of a single-port, lane-maskable BRAM. Accepts masked
// writes (one per cycle), single-outstanding reads with a backpressured
// response, and a bulk clear that fills the whole memory with a value.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   bus            : request/response handshake (bram_mask_ctrl_if.slave)
//   clr_start      : one-cycle pulse, starts a clear (only honoured in IDLE)
//   clr_value      : fill value, captured when the clear starts
//   clr_busy       : high while the clear is sweeping the memory
//   clr_done       : one-cycle pulse the cycle after the last clear write
//   mem_cen        : memory enable, active low (registered)
//   mem_gwen       : 1 = write, 0 = read (registered)
//   mem_wen        : lane write enables (registered)
//   mem_addr       : memory address (registered)
//   mem_din        : memory write data (registered)
//   mem_dout       : memory read data, valid the cycle after a read is sampled
//
// DATA_WIDTH must be an exact multiple of MASK_WIDTH.
// ---------------------------------------------------------------------------
module bram_mask_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 24,
  parameter int MASK_WIDTH = 8,
  localparam int NLANE = DATA_WIDTH / MASK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_mask_ctrl_if.slave       bus,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  mem_cen,
  output logic                  mem_gwen,
  output logic [NLANE-1:0]      mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_RSP   = 2'd2,
    CLEAR    = 2'd3
  } state_t;

  // The clear counter holds the next address to issue; it is one bit wider
  // than the address so that reaching DEPTH marks the end of the sweep.
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state;
  state_t                state_nxt;

  logic [ADDR_WIDTH:0]   clr_cnt;
  logic [ADDR_WIDTH:0]   clr_cnt_nxt;
  logic [DATA_WIDTH-1:0] clr_val;
  logic [DATA_WIDTH-1:0] clr_val_nxt;
  logic                  clr_done_nxt;

  logic                  mem_cen_nxt;
  logic                  mem_gwen_nxt;
  logic [NLANE-1:0]      mem_wen_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_din_nxt;

  logic                  req_accept;
  logic                  clr_last;

  // A pending clr_start blocks acceptance so the clear always wins the cycle.
  assign bus.req_ready = (state == IDLE) && !clr_start;
  assign req_accept    = bus.req_valid && bus.req_ready;
  assign clr_last      = (clr_cnt == CNT_END);

  assign bus.rsp_valid = (state == RD_RSP);
  // The memory is not enabled while in RD_RSP, so mem_dout holds still.
  assign bus.rsp_data  = mem_dout;
  assign clr_busy      = (state == CLEAR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
        end else if (req_accept && !bus.req_we) begin
          state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_RSP;
      RD_RSP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered memory port and clear state.
  // Address/data hold their last value when the port is idle to avoid
  // needless toggling; only mem_cen qualifies the port.
  always_comb begin
    mem_cen_nxt  = 1'b1;
    mem_gwen_nxt = 1'b0;
    mem_wen_nxt  = '0;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;
    clr_cnt_nxt  = clr_cnt;
    clr_val_nxt  = clr_val;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          // Address 0 goes out straight away; the counter resumes at 1.
          mem_cen_nxt  = 1'b0;
          mem_gwen_nxt = 1'b1;
          mem_wen_nxt  = '1;
          mem_addr_nxt = '0;
          mem_din_nxt  = clr_value;
          clr_cnt_nxt  = CNT_ONE;
          clr_val_nxt  = clr_value;
        end else if (req_accept) begin
          mem_cen_nxt  = 1'b0;
          mem_gwen_nxt = bus.req_we;
          mem_wen_nxt  = bus.req_we ? bus.req_wmask : '0;
          mem_addr_nxt = bus.req_addr;
          if (bus.req_we) begin
            mem_din_nxt = bus.req_wdata;
          end
        end
      end
      CLEAR: begin
        if (clr_last) begin
          clr_done_nxt = 1'b1;
        end else begin
          mem_cen_nxt  = 1'b0;
          mem_gwen_nxt = 1'b1;
          mem_wen_nxt  = '1;
          mem_addr_nxt = clr_cnt[ADDR_WIDTH-1:0];
          mem_din_nxt  = clr_val;
          clr_cnt_nxt  = clr_cnt + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Registered memory port and clear bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cen  <= 1'b1;
      mem_gwen <= 1'b0;
      mem_wen  <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      clr_cnt  <= '0;
      clr_val  <= '0;
      clr_done <= 1'b0;
    end else begin
      mem_cen  <= mem_cen_nxt;
      mem_gwen <= mem_gwen_nxt;
      mem_wen  <= mem_wen_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
      clr_cnt  <= clr_cnt_nxt;
      clr_val  <= clr_val_nxt;
      clr_done <= clr_done_nxt;
    end
  end

endmodule
